// File: rtl/fft_frame_pkg.sv
// Shared types and constants for the FFT frame sender.
//   state_e   : sender FSM states
//   N_SAMPLES, SAMPLE_W, BIN_W, WAIT_CYCLES : default frame geometry
//   RX_LATCH_COUNT : receiver counter value at which its result register loads
//   idx_width()    : index width for an n-entry structure (never below 1)
package fft_frame_pkg;

    localparam int unsigned N_SAMPLES      = 8;
    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned BIN_W          = 16;
    localparam int unsigned WAIT_CYCLES    = 4;
    // Receiver counter after the last WAIT edge: N_SAMPLES + WAIT_CYCLES - 1.
    localparam int unsigned RX_LATCH_COUNT = 11;

    typedef enum logic [2:0] {
        StFill,
        StFlush,
        StSend,
        StWait,
        StCapture,
        StHold
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_sample_buf.sv
// One-frame sample store: DEPTH x WIDTH register file.
//   clk     : clock
//   clr     : synchronous clear of every entry (has priority over writes)
//   wr_en   : write strobe
//   wr_idx  : write address
//   wr_data : write data
//   rd_idx  : combinational read address
//   rd_data : combinational read data
module fft_sample_buf
    import fft_frame_pkg::*;
#(
    parameter int unsigned DEPTH = N_SAMPLES,
    parameter int unsigned WIDTH = SAMPLE_W,
    localparam int unsigned IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fft_frame_sender.sv
// Host-side transmitter for the serial-sample FFT receiver. Collects one frame of
// samples, resets the receiver, streams the samples one per clock, clocks the
// receiver through its compute latency, then captures and returns its bin flags.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   s_valid   : upstream sample valid
//   s_data    : upstream sample
//   s_ready   : sender can accept a sample (FILL only)
//   tx_rst_n  : receiver reset (active-low, sync)
//   tx_ena    : receiver enable (SEND/WAIT only)
//   tx_data   : receiver sample input
//   bins_in   : receiver packed bin flags
//   res_valid : captured result valid
//   res_data  : captured bin flags
//   res_ready : downstream accepts result
//   busy      : high in every state except FILL
// All outputs are registered; they are computed from the next state so each
// output is valid during the cycle its state occupies.
module fft_frame_sender
    import fft_frame_pkg::*;
#(
    parameter int unsigned N_SAMPLES   = fft_frame_pkg::N_SAMPLES,
    parameter int unsigned SAMPLE_W    = fft_frame_pkg::SAMPLE_W,
    parameter int unsigned BIN_W       = fft_frame_pkg::BIN_W,
    parameter int unsigned WAIT_CYCLES = fft_frame_pkg::WAIT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                s_ready,
    output logic                tx_rst_n,
    output logic                tx_ena,
    output logic [SAMPLE_W-1:0] tx_data,
    input  logic [BIN_W-1:0]    bins_in,
    output logic                res_valid,
    output logic [BIN_W-1:0]    res_data,
    input  logic                res_ready,
    output logic                busy
);

    localparam int unsigned CNT_W  = $clog2(N_SAMPLES + 1);
    localparam int unsigned PH_MAX = (N_SAMPLES > WAIT_CYCLES) ? N_SAMPLES : WAIT_CYCLES;
    localparam int unsigned PH_W   = idx_width(PH_MAX);
    localparam int unsigned IDX_W  = idx_width(N_SAMPLES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;

    logic                s_ready_q, s_ready_d;
    logic                tx_rst_n_q, tx_rst_n_d;
    logic                tx_ena_q, tx_ena_d;
    logic [SAMPLE_W-1:0] tx_data_q, tx_data_d;
    logic                res_valid_q, res_valid_d;
    logic [BIN_W-1:0]    res_data_q, res_data_d;
    logic                busy_q, busy_d;

    logic                wr_en;
    logic [IDX_W-1:0]    rd_idx;
    logic [SAMPLE_W-1:0] rd_data;

    fft_sample_buf #(
        .DEPTH (N_SAMPLES),
        .WIDTH (SAMPLE_W)
    ) u_buf (
        .clk     (clk),
        .clr     (!rst_n),
        .wr_en   (wr_en),
        .wr_idx  (cnt_q[IDX_W-1:0]),
        .wr_data (s_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        wr_en       = 1'b0;

        unique case (state_q)
            StFill: begin
                if (s_valid && s_ready_q) begin
                    wr_en = 1'b1;
                    if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                        state_d = StFlush;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                state_d = StSend;
                phase_d = '0;
            end
            StSend: begin
                if (phase_q == PH_W'(N_SAMPLES - 1)) begin
                    state_d = StWait;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StWait: begin
                if (phase_q == PH_W'(WAIT_CYCLES - 1)) begin
                    state_d = StCapture;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StCapture: begin
                // Receiver result register loaded on the last WAIT edge.
                state_d     = StHold;
                res_valid_d = 1'b1;
                res_data_d  = bins_in;
            end
            StHold: begin
                if (res_valid_q && res_ready) begin
                    state_d     = StFill;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase

        // Read address follows the next phase so buf[k] is registered out for SEND cycle k.
        rd_idx     = phase_d[IDX_W-1:0];
        s_ready_d  = (state_d == StFill);
        tx_rst_n_d = (state_d != StFlush);
        tx_ena_d   = (state_d == StSend) || (state_d == StWait);
        tx_data_d  = (state_d == StSend) ? rd_data : '0;
        busy_d     = (state_d != StFill);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            phase_q     <= '0;
            s_ready_q   <= 1'b1;
            tx_rst_n_q  <= 1'b0;
            tx_ena_q    <= 1'b0;
            tx_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            s_ready_q   <= s_ready_d;
            tx_rst_n_q  <= tx_rst_n_d;
            tx_ena_q    <= tx_ena_d;
            tx_data_q   <= tx_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign tx_rst_n  = tx_rst_n_q;
    assign tx_ena    = tx_ena_q;
    assign tx_data   = tx_data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fft_frame_sender.sv
// Bench for fft_frame_sender. A behavioural receiver (4-bit counter, loads sample k
// at count k, latches an order-sensitive digest at count 11) supplies bins_in; the
// expected result is the same digest taken directly over the pushed frame.
module tb_fft_frame_sender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        tx_rst_n;
    logic        tx_ena;
    logic [7:0]  tx_data;
    logic [15:0] bins_in;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  frame [8];
    bit          use_const;

    always #5 clk = ~clk;

    fft_frame_sender dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .tx_rst_n  (tx_rst_n),
        .tx_ena    (tx_ena),
        .tx_data   (tx_data),
        .bins_in   (bins_in),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
    );

    function automatic logic [15:0] digest(input logic [7:0] s [8]);
        logic [15:0] acc;
        acc = 16'h0;
        for (int k = 0; k < 8; k++) begin
            acc = {acc[14:0], acc[15]} ^ {s[k], 8'(k + 1)};
        end
        return acc;
    endfunction

    // Receiver model
    logic [3:0]  rx_cnt = 4'd0;
    logic [7:0]  rx_smp [8];
    logic [15:0] rx_res = 16'h0;

    always @(posedge clk) begin
        if (!tx_rst_n) begin
            rx_cnt <= 4'd0;
            rx_res <= 16'h0;
        end else if (tx_ena) begin
            if (rx_cnt < 4'd8) rx_smp[rx_cnt[2:0]] <= tx_data;
            if (rx_cnt == 4'd11) rx_res <= digest(rx_smp);
            rx_cnt <= rx_cnt + 4'd1;
        end
    end

    assign bins_in = use_const ? 16'hA5C3 : rx_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) frame[k] = 8'($urandom);
    endtask

    // Called just after a negedge; returns at the negedge of the FLUSH cycle.
    // mode 0: back-to-back, 1: valid toggles, 2: random gaps.
    task automatic push_frame(input int mode);
        int idx;
        int guard;
        bit hs;
        idx   = 0;
        guard = 0;
        while (idx < 8 && guard < 200) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (guard % 2 == 0);
                default: s_valid = ($urandom_range(3) != 0);
            endcase
            s_data = s_valid ? frame[idx] : 8'($urandom);
            hs = s_valid && s_ready;
            @(negedge clk);
            guard++;
            if (hs) idx++;
        end
        s_valid = 1'b0;
        if (idx != 8) check("push_timeout", 32'(idx), 32'd8);
    endtask

    // Expected {tx_rst_n, tx_ena, tx_data, s_ready, busy} j cycles after the last handshake.
    task automatic check_cycle(input int j);
        logic [11:0] exp;
        if (j == 1)       exp = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        else if (j <= 9)  exp = {1'b1, 1'b1, frame[j-2], 1'b0, 1'b1};
        else if (j <= 13) exp = {1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
        else              exp = {1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        check($sformatf("timeline_c%0d", j), {tx_rst_n, tx_ena, tx_data, s_ready, busy}, exp);
    endtask

    task automatic await_result(input bit full);
        int j;
        j = 1;
        while (!res_valid && j < 40) begin
            if (full && j <= 14) check_cycle(j);
            @(negedge clk);
            j++;
        end
        check("latency", 32'(j - 1), 32'd14);
        check("res_data", res_data, use_const ? 16'hA5C3 : digest(frame));
    endtask

    task automatic release_result(input int delay);
        logic [15:0] held;
        bit bad;
        held = res_data;
        bad  = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (!res_valid || res_data !== held || s_ready || tx_ena || !busy) bad = 1'b1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("release", {res_valid, s_ready, busy}, 3'b010);
        if (delay > 0) check("hold_stable", 32'(bad), 32'd0);
    endtask

    initial begin
        bit bad;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        res_ready = 1'b0;
        use_const = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_tx_ena", tx_ena, 1'b0);
        check("rst_tx_rst_n", tx_rst_n, 1'b0);
        check("rst_res_data", res_data, 16'h0000);
        check("rst_tx_data_busy", {tx_data, busy}, 9'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("fill_tx_rst_n", {tx_rst_n, tx_ena, s_ready}, 3'b101);

        // Frame 1: fixed samples, constant flags, res_ready high from the start.
        for (int k = 0; k < 8; k++) frame[k] = 8'((k + 1) * 16);
        use_const = 1'b1;
        res_ready = 1'b1;
        push_frame(0);
        await_result(1);
        @(negedge clk);
        res_ready = 1'b0;
        check("hold_release", {res_valid, s_ready, busy}, 3'b010);
        use_const = 1'b0;

        // Frame 2: toggling valid, a 9th sample offered, long backpressure.
        rand_frame();
        push_frame(1);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        await_result(1);
        release_result(20);
        s_valid = 1'b0;

        // Frame 3: reset during SEND at k=3, then a clean frame.
        rand_frame();
        push_frame(0);
        repeat (4) @(negedge clk);
        check("pre_reset_k3", {tx_ena, tx_data}, {1'b1, frame[3]});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset", {s_ready, res_valid, tx_ena, tx_rst_n, busy, tx_data, res_data},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000});
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid || tx_ena || !s_ready) bad = 1'b1;
        end
        check("no_partial", 32'(bad), 32'd0);
        rand_frame();
        push_frame(2);
        await_result(1);
        release_result(0);

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            rand_frame();
            push_frame(2);
            await_result(f % 2 == 0);
            release_result(int'($urandom_range(5)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
